spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- SPI-slave register controller that receives configuration frames on the reg SPI pins (reg_sclk/reg_mosi/reg_ss_n) and holds them in shadow registers.
- Pending updates commit to the live registers only at vblank start, so rendering never tears mid-frame.
- Sits between the uio_in SPI pins and the raybox-zero render datapath (sky/floor colours, leak, vshift).
- All logic runs in the pixel clock domain; SPI inputs are oversampled.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on sclk/mosi/ss_n (min 2).
- DATA_W, 6, payload width of each register.
- RST_SKY, 6'b010101, reset value of sky colour.
- RST_FLOOR, 6'b101010, reset value of floor colour.
- RST_LEAK, 6'd0, reset value of leak.
- RST_VSHIFT, 6'd0, reset value of vshift.

Ports:
- clk  in  1  pixel clock, sole clock.
- rst_n  in  1  asynchronous active-low reset.
- i_sclk  in  1  SPI clock, async, mode 0.
- i_mosi  in  1  SPI data, async, MSB first.
- i_ss_n  in  1  SPI select, async, active low.
- i_vblank  in  1  vblank flag, clk domain.
- o_sky  out  DATA_W  live sky colour.
- o_floor  out  DATA_W  live floor colour.
- o_leak  out  DATA_W  live leak.
- o_vshift  out  DATA_W  live vshift.
- o_pending  out  1  at least one shadow is awaiting commit.
- o_busy  out  1  synchronised ss_n is asserted.
- o_frame_err  out  1  one-clk pulse on an aborted or invalid frame.

Behaviour:
- Reset (async, rst_n=0):
  - Live registers and shadows take their RST_* values.
  - Pending flags, o_busy and o_frame_err are 0.
  - FSM goes to IDLE, bit counter to 0, synchronisers load 1 for ss_n and 0 for sclk/mosi.
- Synchronisation and sampling:
  - sclk, mosi and ss_n each pass through SYNC_STAGES flops.
  - A sclk rise is detected as sync=1 with previous=0; mosi is sampled on that clk.
  - Requires f_clk ≥ 4·f_sclk.
  - o_busy = synchronised ss_n inverted.
- Frame format: 10 bits, MSB first.
  - cmd[3:0]: 0=sky, 1=floor, 2=leak, 3=vshift; 4..15 are invalid.
  - Followed by data[DATA_W-1:0].
- FSM states and transitions:
  - IDLE → CMD when synced ss_n falls.
  - CMD: shift 4 bits; after the 4th bit, go to DATA if cmd<4, else pulse o_frame_err and go to IGNORE.
  - DATA: shift DATA_W bits. The cycle after the last bit is sampled, write the addressed shadow, set its pending flag, then go to IGNORE.
  - IGNORE: discard further bits; → IDLE on synced ss_n rise.
  - Any state → IDLE on synced ss_n rise. If that rise happens in CMD or DATA, the frame is discarded (no shadow write) and o_frame_err pulses.
- Commit:
  - On a clk where i_vblank=1 and the registered previous i_vblank=0, every shadow with its pending flag set is copied to its live register.
  - All pending flags clear; live outputs change on the following clk edge.
- Simultaneous shadow write and vblank rise in the same clk: commit uses the old shadows. The new write lands in its shadow and stays pending until the next vblank rise; no write is lost.
- Repeated writes to one register before a commit: the last one wins.
- o_pending = OR of all pending flags.
- Reset mid-frame clears all state; no partial write survives.
- vblank held high produces no additional commits.

Test Plan:
- Reset check: hold rst_n=0 → o_sky=6'b010101, o_floor=6'b101010, o_leak=0, o_vshift=0, o_pending=0, o_busy=0.
- Normal write and commit:
  - Send frame cmd=0, data=6'b110011 with ss_n low, i_vblank=0 → o_pending=1, o_sky unchanged.
  - Pulse i_vblank 0→1 → o_sky=6'b110011 one clk later, o_pending=0.
- Aborted frame: raise ss_n after 7 bits of cmd=1 → o_frame_err pulses exactly once, o_floor and o_pending unchanged after vblank.
- Invalid command: cmd=4'd9 followed by 6 bits → o_frame_err pulse after the 4th bit, no register changes, o_pending=0.
- Write/commit collision: align the shadow write of cmd=2, data=6'd17 to the same clk as the vblank rise → o_leak stays 0, o_pending=1; next vblank rise → o_leak=17.
- Back-to-back writes: send cmd=3 data=5, then cmd=3 data=9, in two ss_n frames before vblank → after commit o_vshift=9; extra trailing bits in a frame are ignored with no error.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI-slave configuration register block: frames land in shadow registers
// and are committed to the live render registers on the rising edge of vblank.
module spi_reg_ctrl #(
   parameter int unsigned       SYNC_STAGES = 2,
   parameter int unsigned       DATA_W      = 6,
   parameter logic [DATA_W-1:0] RST_SKY     = 6'b010101,
   parameter logic [DATA_W-1:0] RST_FLOOR   = 6'b101010,
   parameter logic [DATA_W-1:0] RST_LEAK    = 6'd0,
   parameter logic [DATA_W-1:0] RST_VSHIFT  = 6'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_sclk,
   input  logic              i_mosi,
   input  logic              i_ss_n,
   input  logic              i_vblank,
   output logic [DATA_W-1:0] o_sky,
   output logic [DATA_W-1:0] o_floor,
   output logic [DATA_W-1:0] o_leak,
   output logic [DATA_W-1:0] o_vshift,
   output logic              o_pending,
   output logic              o_busy,
   output logic              o_frame_err
);

   localparam int unsigned CMD_W   = 4;
   localparam int unsigned FRAME_W = CMD_W + DATA_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
   localparam int unsigned NREG    = 4;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_IGN  = 3'd4;

   logic [SYNC_STAGES-1:0]         sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0]         mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0]         ss_sync_q, ss_sync_d;
   logic                           sclk_prev_q, sclk_prev_d;
   logic                           ss_prev_q, ss_prev_d;
   logic                           vblank_prev_q, vblank_prev_d;
   logic [2:0]                     state_q, state_d;
   logic [CNT_W-1:0]               bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]              shift_q, shift_d;
   logic [1:0]                     addr_q, addr_d;
   logic [NREG-1:0][DATA_W-1:0]    shadow_q, shadow_d;
   logic [NREG-1:0][DATA_W-1:0]    live_q, live_d;
   logic [NREG-1:0]                pending_q, pending_d;
   logic                           pending_any_q, pending_any_d;
   logic                           busy_q, busy_d;
   logic                           frame_err_q, frame_err_d;

   logic                           sclk_s, mosi_s, ss_s;
   logic                           sclk_rise, ss_fall, ss_rise, vb_rise;
   logic                           wr_en;
   logic [CMD_W-1:0]               cmd_nxt;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign ss_fall   = ~ss_s & ss_prev_q;
   assign ss_rise   = ss_s & ~ss_prev_q;
   assign vb_rise   = i_vblank & ~vblank_prev_q;
   assign cmd_nxt   = {shift_q[2:0], mosi_s};

   // Input synchronisers and edge-detect history
   always_comb begin
      sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
      ss_sync_d     = {ss_sync_q[SYNC_STAGES-2:0], i_ss_n};
      sclk_prev_d   = sclk_s;
      ss_prev_d     = ss_s;
      vblank_prev_d = i_vblank;
      busy_d        = ~ss_sync_d[SYNC_STAGES-1];
   end

   // Frame receive FSM; a select release always wins over a bit strobe
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      frame_err_d = 1'b0;
      wr_en       = 1'b0;
      if (ss_rise) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         if (state_q == S_CMD || state_q == S_DATA) frame_err_d = 1'b1;
         if (state_q == S_WR) wr_en = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ss_fall) begin
                  state_d   = S_CMD;
                  bit_cnt_d = '0;
               end
            end
            S_CMD: begin
               if (sclk_rise) begin
                  shift_d   = {shift_q[DATA_W-2:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                     addr_d = cmd_nxt[1:0];
                     if (cmd_nxt < CMD_W'(NREG)) begin
                        state_d = S_DATA;
                     end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IGN;
                     end
                  end
               end
            end
            S_DATA: begin
               if (sclk_rise) begin
                  shift_d   = {shift_q[DATA_W-2:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == CNT_W'(FRAME_W - 1)) state_d = S_WR;
               end
            end
            S_WR: begin
               wr_en   = 1'b1;
               state_d = S_IGN;
            end
            S_IGN:   state_d = S_IGN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Shadow/live update: commit reads the old shadows, a same-cycle write stays pending
   always_comb begin
      shadow_d  = shadow_q;
      live_d    = live_q;
      pending_d = vb_rise ? '0 : pending_q;
      if (vb_rise) begin
         for (int i = 0; i < NREG; i++) begin
            if (pending_q[i]) live_d[i] = shadow_q[i];
         end
      end
      if (wr_en) begin
         shadow_d[addr_q]  = shift_q;
         pending_d[addr_q] = 1'b1;
      end
      pending_any_d = |pending_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q   <= '0;
         mosi_sync_q   <= '0;
         ss_sync_q     <= '1;
         sclk_prev_q   <= 1'b0;
         ss_prev_q     <= 1'b1;
         vblank_prev_q <= 1'b0;
         state_q       <= S_IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         addr_q        <= '0;
         shadow_q      <= {RST_VSHIFT, RST_LEAK, RST_FLOOR, RST_SKY};
         live_q        <= {RST_VSHIFT, RST_LEAK, RST_FLOOR, RST_SKY};
         pending_q     <= '0;
         pending_any_q <= 1'b0;
         busy_q        <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         sclk_sync_q   <= sclk_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         ss_sync_q     <= ss_sync_d;
         sclk_prev_q   <= sclk_prev_d;
         ss_prev_q     <= ss_prev_d;
         vblank_prev_q <= vblank_prev_d;
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         addr_q        <= addr_d;
         shadow_q      <= shadow_d;
         live_q        <= live_d;
         pending_q     <= pending_d;
         pending_any_q <= pending_any_d;
         busy_q        <= busy_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign o_sky       = live_q[0];
   assign o_floor     = live_q[1];
   assign o_leak      = live_q[2];
   assign o_vshift    = live_q[3];
   assign o_pending   = pending_any_q;
   assign o_busy      = busy_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios plus randomized frames
// compared against a register-level model of shadows, pending flags and live values.
module tb_spi_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_sclk, i_mosi, i_ss_n, i_vblank;
   logic [5:0] o_sky, o_floor, o_leak, o_vshift;
   logic       o_pending, o_busy, o_frame_err;

   int n_tests = 0;
   int n_fail  = 0;
   int err_cnt = 0;

   logic [5:0] m_shadow [4];
   logic [5:0] m_live   [4];
   bit         m_pend   [4];

   always #5 clk = ~clk;

   spi_reg_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sclk     (i_sclk),
      .i_mosi     (i_mosi),
      .i_ss_n     (i_ss_n),
      .i_vblank   (i_vblank),
      .o_sky      (o_sky),
      .o_floor    (o_floor),
      .o_leak     (o_leak),
      .o_vshift   (o_vshift),
      .o_pending  (o_pending),
      .o_busy     (o_busy),
      .o_frame_err(o_frame_err)
   );

   always @(posedge clk) if (o_frame_err === 1'b1) err_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      m_live[0] = 6'b010101; m_live[1] = 6'b101010; m_live[2] = 6'd0; m_live[3] = 6'd0;
      for (int i = 0; i < 4; i++) begin
         m_shadow[i] = m_live[i];
         m_pend[i]   = 1'b0;
      end
   endfunction

   function automatic void m_write(input int a, input logic [5:0] d);
      m_shadow[a] = d;
      m_pend[a]   = 1'b1;
   endfunction

   function automatic void m_commit();
      for (int i = 0; i < 4; i++) begin
         if (m_pend[i]) m_live[i] = m_shadow[i];
         m_pend[i] = 1'b0;
      end
   endfunction

   function automatic logic m_any();
      return m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".sky"},     32'(o_sky),     32'(m_live[0]));
      chk({tag, ".floor"},   32'(o_floor),   32'(m_live[1]));
      chk({tag, ".leak"},    32'(o_leak),    32'(m_live[2]));
      chk({tag, ".vshift"},  32'(o_vshift),  32'(m_live[3]));
      chk({tag, ".pending"}, 32'(o_pending), 32'(m_any()));
   endtask

   // Bit-bangs one select window of nbits (MSB first); optional vblank rise aligned to the shadow write
   task automatic spi_frame(input logic [3:0] cmd, input logic [5:0] data, input int nbits,
                            input bit collide);
      logic [15:0] w;
      w = {cmd, data, 6'($urandom)};
      @(negedge clk) i_ss_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         i_mosi = w[15-i];
         repeat (4) @(negedge clk);
         i_sclk = 1'b1;
         if (collide && i == nbits - 1) begin
            repeat (3) @(negedge clk);
            i_vblank = 1'b1;
            @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
         i_sclk = 1'b0;
      end
      repeat (6) @(negedge clk);
      i_ss_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic vblank_pulse();
      @(negedge clk) i_vblank = 1'b1;
      m_commit();
      repeat (3) @(negedge clk);
      i_vblank = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int e0;
      rst_n = 1'b0; i_sclk = 1'b0; i_mosi = 1'b0; i_ss_n = 1'b1; i_vblank = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      check_all("reset");
      chk("reset.busy", 32'(o_busy), 32'd0);
      chk("reset.err",  32'(o_frame_err), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Normal write then commit
      spi_frame(4'd0, 6'b110011, 10, 1'b0);
      m_write(0, 6'b110011);
      check_all("wr_sky");
      chk("wr_sky.held", 32'(o_sky), 32'(6'b010101));
      @(negedge clk) i_vblank = 1'b1;
      m_commit();
      @(negedge clk);
      check_all("commit_sky");
      chk("commit_sky.val", 32'(o_sky), 32'(6'b110011));
      i_vblank = 1'b0;
      repeat (2) @(negedge clk);

      // Busy follows the synchronised select
      @(negedge clk) i_ss_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy.high", 32'(o_busy), 32'd1);
      i_ss_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("busy.low", 32'(o_busy), 32'd0);
      e0 = err_cnt;
      chk("busy.empty_abort", 32'(err_cnt - e0 + 1), 32'd1);
      e0 = err_cnt;

      // Aborted frame after 7 bits
      spi_frame(4'd1, 6'b001100, 7, 1'b0);
      chk("abort.err", 32'(err_cnt - e0), 32'd1);
      vblank_pulse();
      check_all("abort");

      // Invalid command
      e0 = err_cnt;
      spi_frame(4'd9, 6'b111111, 10, 1'b0);
      chk("badcmd.err", 32'(err_cnt - e0), 32'd1);
      check_all("badcmd");
      vblank_pulse();
      check_all("badcmd.vb");

      // Shadow write coincides with vblank rise
      e0 = err_cnt;
      spi_frame(4'd2, 6'd17, 10, 1'b1);
      m_commit();
      m_write(2, 6'd17);
      check_all("collide");
      chk("collide.leak", 32'(o_leak), 32'd0);
      chk("collide.err", 32'(err_cnt - e0), 32'd0);
      i_vblank = 1'b0;
      repeat (2) @(negedge clk);
      vblank_pulse();
      check_all("collide.next");
      chk("collide.leak17", 32'(o_leak), 32'd17);

      // Back-to-back writes, second with trailing bits
      e0 = err_cnt;
      spi_frame(4'd3, 6'd5, 10, 1'b0);
      m_write(3, 6'd5);
      spi_frame(4'd3, 6'd9, 13, 1'b0);
      m_write(3, 6'd9);
      chk("b2b.err", 32'(err_cnt - e0), 32'd0);
      vblank_pulse();
      check_all("b2b");
      chk("b2b.vshift", 32'(o_vshift), 32'd9);

      // vblank held high: no further commits
      @(negedge clk) i_vblank = 1'b1;
      m_commit();
      spi_frame(4'd1, 6'd33, 10, 1'b0);
      m_write(1, 6'd33);
      repeat (10) @(negedge clk);
      check_all("vbhold");
      i_vblank = 1'b0;
      repeat (2) @(negedge clk);
      vblank_pulse();
      check_all("vbhold.after");

      // Randomized frames
      for (int it = 0; it < 40; it++) begin
         logic [3:0] cmd;
         logic [5:0] data;
         int         nb, r;
         cmd  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         data = 6'($urandom);
         r    = int'($urandom_range(0, 3));
         nb   = (r < 2) ? 10 : (r == 2) ? int'($urandom_range(11, 16)) : int'($urandom_range(0, 9));
         e0   = err_cnt;
         spi_frame(cmd, data, nb, 1'b0);
         if (cmd < 4'd4 && nb >= 10) m_write(int'(cmd), data);
         chk("rnd.err", 32'(err_cnt - e0), (cmd < 4'd4 && nb >= 10) ? 32'd0 : 32'd1);
         if ($urandom_range(0, 2) == 0) vblank_pulse();
         check_all("rnd");
      end

      // Reset in the middle of a frame
      spi_frame(4'd0, 6'd7, 10, 1'b0);
      @(negedge clk) i_ss_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         i_mosi = i[0];
         repeat (4) @(negedge clk);
         i_sclk = 1'b1;
         repeat (4) @(negedge clk);
         i_sclk = 1'b0;
      end
      rst_n = 1'b0; i_ss_n = 1'b1; i_sclk = 1'b0;
      m_reset();
      @(negedge clk);
      check_all("midrst");
      chk("midrst.busy", 32'(o_busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      vblank_pulse();
      check_all("midrst.vb");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
